// File: rtl/dff_delay_line_prog.sv
`default_nettype none
// ============================================================================
// Module   : dff_delay_line_prog
// Brief    : Multi-bit delay line with a runtime-programmable tap.
//            A valid bit travels with each sample. The line supports a
//            clock-enable stall, a synchronous flush, and output blanking
//            after every tap change.
// Revision : 1.0 - initial release
// ============================================================================
module dff_delay_line_prog #(
    parameter  int WIDTH       = 8,
    parameter  int MAX_TAP     = 16,
    parameter  int DEFAULT_TAP = 3,
    localparam int TAP_W       = $clog2(MAX_TAP + 1)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             en,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    input  logic             flush,
    input  logic             tap_load,
    input  logic [TAP_W-1:0] tap_sel,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    output logic             busy,
    output logic [TAP_W-1:0] tap_cur
);

    localparam int               IDX_W         = (MAX_TAP > 1) ? $clog2(MAX_TAP) : 1;
    localparam logic [TAP_W-1:0] MAX_TAP_C     = TAP_W'(MAX_TAP);
    localparam logic [TAP_W-1:0] DEFAULT_TAP_C = TAP_W'(DEFAULT_TAP);
    localparam logic [TAP_W-1:0] ONE_C         = TAP_W'(1);

    logic [WIDTH-1:0]   data_q [MAX_TAP];
    logic [WIDTH-1:0]   data_d [MAX_TAP];
    logic [MAX_TAP-1:0] valid_q;
    logic [MAX_TAP-1:0] valid_d;
    logic [TAP_W-1:0]   tap_q;
    logic [TAP_W-1:0]   tap_d;
    logic [TAP_W-1:0]   blank_q;
    logic [TAP_W-1:0]   blank_d;
    logic [TAP_W-1:0]   tap_clamped;
    logic [IDX_W-1:0]   out_idx;

    // Clamp the requested delay into the legal range 1..MAX_TAP.
    always_comb begin
        tap_clamped = tap_sel;
        if (tap_sel == '0) begin
            tap_clamped = ONE_C;
        end else if (tap_sel > MAX_TAP_C) begin
            tap_clamped = MAX_TAP_C;
        end
    end

    // Next-state logic: flush beats shift and owns the blanking counter;
    // a tap load arms blanking without decrementing on its own edge.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        tap_d   = tap_q;
        blank_d = blank_q;
        if (flush) begin
            valid_d = '0;
            blank_d = '0;
            if (tap_load) begin
                tap_d = tap_clamped;
            end
        end else begin
            if (en) begin
                data_d[0] = in_data;
                for (int k = 1; k < MAX_TAP; k++) begin
                    data_d[k] = data_q[k-1];
                end
                valid_d = {valid_q[MAX_TAP-2:0], in_valid};
            end
            if (tap_load) begin
                tap_d   = tap_clamped;
                blank_d = tap_clamped;
            end else if (en && (blank_q != '0)) begin
                blank_d = blank_q - ONE_C;
            end
        end
    end

    // State registers with asynchronous active-low clear.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int k = 0; k < MAX_TAP; k++) begin
                data_q[k] <= '0;
            end
            valid_q <= '0;
            tap_q   <= DEFAULT_TAP_C;
            blank_q <= '0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            tap_q   <= tap_d;
            blank_q <= blank_d;
        end
    end

    // Output tap mux: stage tap_cur-1 holds a sample delayed tap_cur edges.
    always_comb begin
        out_idx   = IDX_W'(tap_q - ONE_C);
        out_data  = data_q[out_idx];
        out_valid = valid_q[out_idx] & (blank_q == '0);
        busy      = (blank_q != '0);
        tap_cur   = tap_q;
    end

endmodule
`default_nettype wire
